// File: rtl/avalon_debounced_pio_in.sv
// avalon_debounced_pio_in: Avalon-MM input PIO for switch/button banks.
// Inputs are synchronised, optionally debounced per bit, edge-detected into a
// write-1-to-clear edgecapture register, and combined with irqmask into a level
// interrupt.
// Build option: define PIO_IN_DEBOUNCE_EN to instantiate the per-bit debounce
// counters; without it every synchronised input is accepted one cycle later and
// DEBOUNCE_CYCLES has no effect.
//
// Register map (word address):
//   0 data (debounced level), 1 reserved (reads 0), 2 irqmask, 3 edgecapture
module avalon_debounced_pio_in #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] clr;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en = chipselect & ~write_n;

  // Bits of writedata above WIDTH are intentionally ignored.
  assign unused_wdata = ^writedata;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [WIDTH];

  // Per-bit debounce: a new level must persist DEBOUNCE_CYCLES samples; any
  // return to the accepted level restarts the count, so it never passes CNT_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  // No debounce: accept the synchronised level every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
    end else begin
      stable <= sync2;
    end
  end
`endif

  // Previous accepted level, for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
    end else begin
      prev <= stable;
    end
  end

  // Edge selection and write-1-to-clear mask for edgecapture.
  always_comb begin
    rise = stable & ~prev;
    fall = ~stable & prev;
    if (EDGE_TYPE == 0) begin
      edge_sel = rise;
    end else if (EDGE_TYPE == 1) begin
      edge_sel = fall;
    end else begin
      edge_sel = rise | fall;
    end
    clr = '0;
    if (wr_en && (address == 2'd3)) begin
      clr = writedata[WIDTH-1:0];
    end
  end

  // irqmask write, edge capture (a new edge wins over a clear), registered irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask     <= '0;
      edgecapture <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr_en && (address == 2'd2)) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      edgecapture <= (edgecapture & ~clr) | edge_sel;
      irq         <= |(edgecapture & irqmask);
    end
  end

  // Read mux, registered every cycle independent of chipselect.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(stable);
        2'd1:    readdata <= '0;
        2'd2:    readdata <= 32'(irqmask);
        default: readdata <= 32'(edgecapture);
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_debounced_pio_in.sv
// Bench for avalon_debounced_pio_in: two instances (rising-edge and any-edge
// capture) share the bus and pins; a queue-based reference model predicts
// readdata and irq for every cycle.
module tb_avalon_debounced_pio_in;
  localparam int W = 4;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 1;
`endif
  localparam int ET[2] = '{0, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd0, rd2;
  logic          irq0, irq2;

  int checks = 0;
  int errors = 0;

  avalon_debounced_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  avalon_debounced_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  // Reference model: pin history queue plus architectural registers.
  logic [W-1:0]  inq[$];
  logic [W-1:0]  m_stable, m_prev, m_mask;
  logic [W-1:0]  m_ecap [2];
  logic [31:0]   m_rd [2];
  logic          m_irq [2];

  // A level is accepted once the DEB most recent synchronised samples (pins
  // sampled 2..DEB+1 edges ago) all differ from the currently accepted level.
  task automatic model_step();
    logic [W-1:0] ns, rise, fall, sel, clr, s;
    logic         all_diff;
    int           n;
    if (reset) begin
      inq.delete();
      for (int j = 0; j <= DEB; j++) inq.push_back('0);
      m_stable = '0; m_prev = '0; m_mask = '0;
      for (int k = 0; k < 2; k++) begin
        m_ecap[k] = '0; m_rd[k] = '0; m_irq[k] = 1'b0;
      end
    end else begin
      n  = inq.size();
      ns = m_stable;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DEB; j++) begin
          s = inq[n-1-j];
          if (s[b] == m_stable[b]) all_diff = 1'b0;
        end
        if (all_diff) ns[b] = ~m_stable[b];
      end
      rise = m_stable & ~m_prev;
      fall = ~m_stable & m_prev;
      clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int k = 0; k < 2; k++) begin
        if (ET[k] == 0) sel = rise;
        else if (ET[k] == 1) sel = fall;
        else sel = rise | fall;
        case (address)
          2'd0:    m_rd[k] = 32'(m_stable);
          2'd1:    m_rd[k] = '0;
          2'd2:    m_rd[k] = 32'(m_mask);
          default: m_rd[k] = 32'(m_ecap[k]);
        endcase
        m_irq[k]  = |(m_ecap[k] & m_mask);
        m_ecap[k] = (m_ecap[k] & ~clr) | sel;
      end
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_prev   = m_stable;
      m_stable = ns;
      inq.push_back(in_port);
      void'(inq.pop_front());
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model_rd_rise", rd0, m_rd[0]);
    check("model_rd_any", rd2, m_rd[1]);
    check("model_irq_rise", {31'b0, irq0}, {31'b0, m_irq[0]});
    check("model_irq_any", {31'b0, irq2}, {31'b0, m_irq[1]});
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    chipselect = 1'b1; address = a;
    tick();
    chipselect = 1'b0;
  endtask

  task automatic wait_stable(input int b, input logic v);
    int n = 0;
    while (m_stable[b] !== v && n < 4 * DEB + 10) begin
      tick();
      n++;
    end
    if (m_stable[b] !== v) begin
      checks++;
      errors++;
      $display("FAIL wait_stable bit %0d: level %b not reached", b, v);
    end
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];
  int   hold[W];

  initial begin
    // Register-map vectors, applied with stable=F, edgecapture=F, irqmask=0.
    vecs[0] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'hF};
    vecs[2] = '{1'b1, 1'b1, 2'd1, 32'h0,         32'h0};
    vecs[3] = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 2'd0, 32'h0,         32'hF};
    vecs[5] = '{1'b1, 1'b1, 2'd0, 32'h0,         32'hF};
    vecs[6] = '{1'b1, 1'b0, 2'd3, 32'h5,         32'hF};
    vecs[7] = '{1'b1, 1'b1, 2'd3, 32'h0,         32'hA};
    vecs[8] = '{1'b1, 1'b0, 2'd2, 32'h0,         32'hF};
    vecs[9] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h0};

    reset = 1'b1; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0;

    // Reset with pins high, then watch the debounced level appear.
    repeat (3) tick();
    check("reset_rd", rd0, 32'h0);
    check("reset_irq", {31'b0, irq0}, 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= DEB + 4; k++) begin
      address = (k < DEB + 3) ? 2'(k % 4) : 2'd0;
      tick();
      check("reset_release_rd", rd0, (k >= DEB + 3) ? 32'hF : 32'h0);
    end

    // Table-driven register map vectors.
    for (int i = 0; i < 10; i++) begin
      chipselect = vecs[i].cs; write_n = vecs[i].wn;
      address = vecs[i].addr; writedata = vecs[i].wdata;
      tick();
      check($sformatf("vec%0d_rise", i), rd0, vecs[i].exp_rd);
      check($sformatf("vec%0d_any", i), rd2, vecs[i].exp_rd);
    end
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;

    in_port = 4'h0;
    repeat (DEB + 4) tick();
    bus_write(2'd3, 32'hF);

    // Glitch one cycle shorter than the debounce window.
    bus_write(2'd2, 32'h1);
    in_port[0] = 1'b1;
    repeat (DEB - 1) tick();
    in_port[0] = 1'b0;
    repeat (DEB + 4) tick();
    bus_read(2'd0);
    check("glitch_stable", rd0, 32'h0);
    bus_read(2'd3);
    check("glitch_ecap_rise", rd0, 32'h0);
    check("glitch_ecap_any", rd2, 32'h0);
    check("glitch_irq", {31'b0, irq0}, 32'h0);

    // Debounced rise: irq two edges after stable rises, cleared by W1C.
    in_port[0] = 1'b1;
    wait_stable(0, 1'b1);
    tick();
    check("rise_irq_edge1", {31'b0, irq0}, 32'h0);
    tick();
    check("rise_irq_edge2", {31'b0, irq0}, 32'h1);
    bus_read(2'd3);
    check("rise_ecap", rd0, 32'h1);
    bus_write(2'd3, 32'h1);
    tick();
    check("rise_irq_cleared", {31'b0, irq0}, 32'h0);
    bus_read(2'd3);
    check("rise_ecap_cleared", rd0, 32'h0);

    // Falling edge: only the any-edge instance captures it.
    in_port[0] = 1'b0;
    wait_stable(0, 1'b0);
    repeat (2) tick();
    bus_read(2'd3);
    check("fall_ecap_rise", rd0, 32'h0);
    check("fall_ecap_any", rd2, 32'h1);
    bus_write(2'd3, 32'hF);

    // Clear of bit 2 on the very edge it captures: set wins.
    in_port[2] = 1'b1;
    wait_stable(2, 1'b1);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3);
    check("setclr_rise", rd0, 32'h4);
    check("setclr_any", rd2, 32'h4);

    // Masking: bits 1 and 3 capture, irq follows bit 1 only.
    bus_write(2'd2, 32'h2);
    in_port = 4'b1110;
    wait_stable(1, 1'b1);
    repeat (2) tick();
    check("mask_irq_on", {31'b0, irq0}, 32'h1);
    bus_read(2'd3);
    check("mask_ecap", rd0, 32'hE);
    bus_write(2'd3, 32'h2);
    tick();
    check("mask_irq_off", {31'b0, irq0}, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2);
    check("mask_readback", rd0, 32'hF);
    bus_read(2'd1);
    check("reserved_rd", rd0, 32'h0);

    // One-cycle pulse on bit 3: passes only when debounce is compiled out.
    bus_write(2'd2, 32'h0);
    in_port = 4'h0;
    wait_stable(1, 1'b0);
    repeat (3) tick();
    bus_write(2'd3, 32'hF);
    address = 2'd0;
    in_port[3] = 1'b1;
    tick();
    in_port[3] = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      check("pulse_rd", rd0, (j == 3 && DEB == 1) ? 32'h8 : 32'h0);
    end
    tick();
    bus_read(2'd3);
    check("pulse_ecap_any", rd2, (DEB == 1) ? 32'h8 : 32'h0);

    // Randomised pins, bus traffic and occasional reset against the model.
    for (int b = 0; b < W; b++) hold[b] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          in_port[b] = 1'($urandom_range(1, 0));
          hold[b] = $urandom_range(2 * DEB + 1, 1);
        end else begin
          hold[b]--;
        end
      end
      chipselect = 1'($urandom_range(1, 0));
      write_n    = ($urandom_range(3, 0) != 0);
      address    = 2'($urandom_range(3, 0));
      writedata  = $urandom;
      reset      = ($urandom_range(299, 0) == 0);
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
